// File: rtl/mskmc_col_scheduler_pkg.sv
// Shared constants, FSM encoding and the unmasked MixColumns column function
// for the masked column scheduler.
package mskmc_col_scheduler_pkg;

  localparam int unsigned COL_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns of one share; byte k (row k) at [8*k +: 8].
  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] a);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    logic [BYTE_W-1:0] b0, b1, b2, b3;
    a0 = a[0*BYTE_W +: BYTE_W];
    a1 = a[1*BYTE_W +: BYTE_W];
    a2 = a[2*BYTE_W +: BYTE_W];
    a3 = a[3*BYTE_W +: BYTE_W];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/mskmc_col_datapath.sv
// Combinational masked MixColumns with a sharewise final-round bypass.
// Each share is de-interleaved, mixed on its own and re-interleaved.
module mskmc_col_datapath
  import mskmc_col_scheduler_pkg::*;
#(
  parameter int unsigned d = 2
) (
  input  logic [COL_W*d-1:0] col,
  input  logic               last_round,
  output logic [COL_W*d-1:0] col_out
);

  // Share j bit b (b = 8*row + bit) lives at index d*b + j.
  for (genvar gj = 0; gj < d; gj++) begin : g_share
    logic [COL_W-1:0] sh_in;
    logic [COL_W-1:0] sh_mix;

    assign sh_mix = mix_col(sh_in);

    for (genvar gb = 0; gb < COL_W; gb++) begin : g_bit
      assign sh_in[gb]             = col[d*gb + gj];
      assign col_out[d*gb + gj]    = last_round ? col[d*gb + gj] : sh_mix[gb];
    end
  end

endmodule

// File: rtl/mskmc_col_scheduler.sv
// Column scheduler for the masked MixColumns stage: counts four columns per
// state, latches the final-round flag on column 0 and registers the result.
module mskmc_col_scheduler
  import mskmc_col_scheduler_pkg::*;
#(
  parameter int unsigned d = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COL_W*d-1:0] in_col,
  input  logic               in_last_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COL_W*d-1:0] out_col,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last_round,
  output logic               busy
);

  localparam int unsigned DW = COL_W * d;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               lr_q, lr_d;
  logic               in_fire;
  logic               out_fire;
  logic               eff_lr;
  logic [DW-1:0]      dp_col;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state_q == ACTIVE) || out_valid;

  // Column 0 takes its flag straight from the input; later columns use the latch.
  assign eff_lr   = (state_q == IDLE) ? in_last_round : lr_q;

  mskmc_col_datapath #(
    .d (d)
  ) u_datapath (
    .col        (in_col),
    .last_round (eff_lr),
    .col_out    (dp_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          lr_d    = in_last_round;
          cnt_d   = IDX_W'(1);
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (in_fire) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(3)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output stage: an accept always reloads, a bare release only drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_col        <= '0;
      out_idx        <= '0;
      out_last_round <= 1'b0;
    end else if (in_fire) begin
      out_valid      <= 1'b1;
      out_col        <= dp_col;
      out_idx        <= cnt_q;
      out_last_round <= eff_lr;
    end else if (out_fire) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mskmc_col_scheduler.sv
// Self-checking bench for mskmc_col_scheduler (d=2) against a cycle-level
// reference model built from GF(2^8) arithmetic and a column counter.
module tb_mskmc_col_scheduler;

  localparam int unsigned D  = 2;
  localparam int unsigned DW = 32 * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_col = '0;
  logic          in_last_round = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_col;
  logic [1:0]    out_idx;
  logic          out_last_round;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit            m_valid;
  logic [DW-1:0] m_col;
  int            m_idx;
  bit            m_lr;
  int            m_cnt;
  bit            m_lrs;

  always #5 clk = ~clk;

  mskmc_col_scheduler #(.d(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_col         (in_col),
    .in_last_round  (in_last_round),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_col        (out_col),
    .out_idx        (out_idx),
    .out_last_round (out_last_round),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_mix(input logic [31:0] w);
    logic [7:0] a [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) a[k] = w[8*k +: 8];
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = gmul(a[k], 8'd2) ^ gmul(a[(k+1)%4], 8'd3) ^ a[(k+2)%4] ^ a[(k+3)%4];
    return r;
  endfunction

  function automatic logic [DW-1:0] pack2(input logic [31:0] s0, input logic [31:0] s1);
    logic [DW-1:0] r;
    for (int b = 0; b < 32; b++) begin
      r[2*b]   = s0[b];
      r[2*b+1] = s1[b];
    end
    return r;
  endfunction

  function automatic logic [31:0] share_of(input logic [DW-1:0] c, input int j);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = c[2*b + j];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_masked(input logic [DW-1:0] c);
    return pack2(ref_mix(share_of(c, 0)), ref_mix(share_of(c, 1)));
  endfunction

  function automatic logic [DW-1:0] mask_col(input logic [31:0] plain, input logic [31:0] r);
    return pack2(plain ^ r, r);
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".busy"}, 64'(busy), 64'((m_cnt != 0) || m_valid));
    if (m_valid) begin
      chk({tag, ".out_col"}, out_col, m_col);
      chk({tag, ".out_idx"}, 64'(out_idx), 64'(m_idx));
      chk({tag, ".out_lr"}, 64'(out_last_round), 64'(m_lr));
    end
  endtask

  // One clock cycle: entered and left at a negedge.
  task automatic step(input string tag, input bit v, input logic [DW-1:0] col,
                      input bit lr, input bit rdy);
    bit m_rdy, acc, rel, eff;
    in_valid = v; in_col = col; in_last_round = lr; out_ready = rdy;
    #1;
    m_rdy = !m_valid || rdy;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(m_rdy));
    acc = v && m_rdy;
    rel = m_valid && rdy;
    @(posedge clk);
    if (acc) begin
      eff = (m_cnt == 0) ? lr : m_lrs;
      if (m_cnt == 0) m_lrs = lr;
      m_col   = eff ? col : ref_masked(col);
      m_idx   = m_cnt;
      m_lr    = eff;
      m_cnt   = (m_cnt + 1) % 4;
      m_valid = 1'b1;
    end else if (rel) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk_out(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_col = '0; m_idx = 0; m_lr = 1'b0; m_cnt = 0; m_lrs = 1'b0;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_col", out_col, 64'd0);
    chk("rst.out_idx", 64'(out_idx), 64'd0);
    chk("rst.out_lr", 64'(out_last_round), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic chk_plain(input string tag, input logic [31:0] exp);
    chk(tag, 64'(share_of(out_col, 0) ^ share_of(out_col, 1)), 64'(exp));
  endtask

  initial begin
    logic [31:0] plain_in  [4];
    logic [31:0] plain_exp [4];
    logic [DW-1:0] c;
    bit lr;

    do_reset();

    // unmasked single column, share1 = 0
    step("t1", 1'b1, mask_col(32'h4553_13db, 32'h0), 1'b0, 1'b1);
    chk_plain("t1.plain", 32'hbca1_4d8e);
    chk("t1.idx", 64'(out_idx), 64'd0);
    do_reset();

    // four masked columns with fresh randomness each
    plain_in  = '{32'h5c22_0af2, 32'h0101_0101, 32'hc6c6_c6c6, 32'hd5d4_d4d4};
    plain_exp = '{32'h9d58_dc9f, 32'h0101_0101, 32'hc6c6_c6c6, 32'hd6d7_d5d5};
    for (int k = 0; k < 4; k++) begin
      step("t2", 1'b1, mask_col(plain_in[k], $urandom), 1'b0, 1'b1);
      chk_plain("t2.plain", plain_exp[k]);
      chk("t2.idx", 64'(out_idx), 64'(k));
    end
    step("t2.drain", 1'b0, '0, 1'b0, 1'b1);

    // final-round state: bypass on all four columns
    for (int k = 0; k < 4; k++) begin
      c = {$urandom, $urandom};
      step("t3", 1'b1, c, (k == 0), 1'b1);
      chk("t3.bypass", out_col, c);
      chk("t3.lr", 64'(out_last_round), 64'd1);
    end
    step("t3.drain", 1'b0, '0, 1'b1, 1'b1);

    // backpressure for five cycles
    step("t4.a", 1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    c = {$urandom, $urandom};
    for (int k = 0; k < 5; k++) step("t4.stall", 1'b1, c, 1'b0, 1'b0);
    step("t4.rel", 1'b1, c, 1'b0, 1'b1);
    chk("t4.idx", 64'(out_idx), 64'd1);
    for (int k = 0; k < 2; k++) step("t4.fill", 1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
    step("t4.drain", 1'b0, '0, 1'b0, 1'b1);

    // two back-to-back states, second one final-round
    for (int k = 0; k < 8; k++) begin
      lr = (k == 4) ? 1'b1 : (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      step("t5", 1'b1, {$urandom, $urandom}, lr, 1'b1);
      chk("t5.idx", 64'(out_idx), 64'(k % 4));
      chk("t5.lr", 64'(out_last_round), 64'(k >= 4));
    end
    step("t5.drain", 1'b0, '0, 1'b0, 1'b1);

    // reset in the middle of a state
    for (int k = 0; k < 2; k++) step("t6", 1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    do_reset();
    step("t6.post", 1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
    chk("t6.idx", 64'(out_idx), 64'd0);

    // randomized traffic
    for (int n = 0; n < 500; n++)
      step("rnd", ($urandom_range(0, 3) != 0), {$urandom, $urandom},
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mskmc_col_scheduler.md
Name: mskmc_col_scheduler

Overview:
- Sequences the masked MixColumns datapath for the 32-bit-per-cycle AES encryption core.
- Accepts one masked state column per handshake, four columns per state, and applies MixColumns sharewise to each.
- Bypasses MixColumns for every column of a state flagged as final-round.
- Registers the result behind a valid/ready output stage with per-column index tracking. Holds no randomness; the operation is linear and sharewise.

Parameters:
- d, 2, number of shares (masking order d-1); must be >= 2.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input column valid
- in_ready  output  1  scheduler can accept a column this cycle
- in_col  input  32*d  masked column: byte k (k=0..3, row k) at bits [8*d*k +: 8*d]; within a byte, bit i share j at index d*i+j
- in_last_round  input  1  final-round flag; sampled only on the column-0 handshake
- out_valid  output  1  output column valid
- out_ready  input  1  downstream accepts output column
- out_col  output  32*d  processed masked column, same layout as in_col
- out_idx  output  2  column index (0..3) of out_col within its state
- out_last_round  output  1  final-round flag of the state out_col belongs to
- busy  output  1  high while a state is partially accepted or out_valid is high

Behaviour:
- Input handshake: accept on in_valid && in_ready. Output handshake: release on out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a combinational pass-through, giving full throughput of one column per cycle.
- Latency: an accepted column appears on out_col the next cycle.
- Output transform:
  - Non-final state: out_col = MixColumns(in_col) per share (b0 = 2a0^3a1^a2^a3, etc.).
  - Final-round state: out_col = in_col.
- Column counter cnt (2 bits), FSM states:
  - IDLE (cnt=0): on accept, latch lr_q <= in_last_round, cnt <= 1, go to ACTIVE.
  - ACTIVE: each accept increments cnt. Accepting with cnt=3 wraps cnt to 0 and returns to IDLE.
  - in_last_round is ignored in ACTIVE; lr_q applies to all 4 columns of the state.
- Output register loads on every accept, whether or not it coincides with an output release:
  - out_col, out_idx <= cnt, out_last_round <= (IDLE ? in_last_round : lr_q).
  - out_valid <= 1.
- Release without a simultaneous accept: out_valid <= 0. Data registers hold their value and are don't-care.
- Stall: while out_valid && !out_ready, in_ready is 0 and out_col, out_idx, out_last_round are stable.
- Back-to-back states: a column-0 accept in the cycle after the column-3 accept starts the next state with no bubble.
- busy = (state==ACTIVE) || out_valid.
- Reset values: out_valid=0, out_col=0, out_idx=0, out_last_round=0, cnt=0, lr_q=0, state IDLE. busy=0 and in_ready=1 one cycle after reset.
- Reset mid-state discards partial columns and the pending output. The next accepted column is treated as column 0.
- Shares never mix: output share j depends only on input share j. No share recombination is permitted anywhere, including the bypass mux, whose select is a non-sensitive control signal.

Decomposition:
- Shared package holds:
  - column width constant (32 bits per share)
  - column index width (2)
  - FSM state encoding {IDLE, ACTIVE}
- Sub-module: mskmc_col_datapath. It is purely combinational: the existing masked MixColumns module plus a sharewise bypass mux selected by the effective last-round flag.
- The scheduler holds the FSM, counter, flag latch and output register.

Test Plan:
- d=2, share1=0, in_last_round=0, column bytes (a0..a3)=db,13,53,45 -> unmasked out bytes 8e,4d,a1,bc; out_idx=0; valid one cycle after accept.
- d=2, random share1 R each column, 4 columns f2,0a,22,5c / 01,01,01,01 / c6,c6,c6,c6 / d4,d4,d4,d5 -> unmasked 9f,dc,58,9d / 01,01,01,01 / c6,c6,c6,c6 / d5,d5,d7,d6; out_idx 0,1,2,3; cnt back to IDLE.
- Final round: in_last_round=1 on column 0, then 0 on columns 1-3 -> all 4 outputs equal their inputs, out_last_round=1 for all 4.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and outputs stable; release -> next column accepted in the same cycle, no column lost or duplicated.
- Back-to-back: 8 columns streamed with out_ready=1 -> 8 outputs on consecutive cycles, out_idx 0,1,2,3,0,1,2,3, second state's flag taken from its own column 0.
- rst asserted after 2 columns -> out_valid=0, busy=0 next cycle; next accepted column reported with out_idx=0.
